pipe_sched: RTL

- Scheduler that shares one fixed-latency, non-stallable arithmetic pipe (four N-bit operands a/b/c/d in, one N-bit result f out) between two requesters.
- Arbitrates operand issue round-robin and tracks in-flight operations with a valid/ID shift register.
- Buffers results in a small FIFO and returns each result to the requester that issued it, via a valid/ready handshake.
- Sits between requester logic and the pipe instance; the pipe itself is unchanged.

---
 rtl/pipe_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipe_sched.sv
// pipe_sched: shares one fixed-latency, non-stallable arithmetic pipe between two requesters.
// Optional build macro PIPE_SCHED_FIXED_PRIO_EN: strict req0-first priority, no round-robin pointer.
// Default build (macro undefined): round-robin arbitration between the requesters.

// sched_fifo: generic synchronous FIFO holding results waiting for the consumer.
// Latency: a push is visible at the head one cycle later (no bypass when empty).
// Backpressure: producer must not push when full unless it also pops that cycle.
module sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] dat_o,
    output logic         vld_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         full;

    // Extra MSB on each pointer tells full from empty; low bits index modulo DEPTH.
    assign vld_o = (wr_ptr_q != rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Head forced to zero while empty so the output is clean after reset.
    assign dat_o = vld_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    // Read/write pointer update; push and pop in one cycle are both honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; no reset needed, the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= dat_i;
    end

    // Overflow can only happen if the credit limit is broken upstream.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push_i && full && !pop_i));
    end
endmodule

// pipe_sched: arbitrates two requesters onto a shared pipe and routes results back by ID.
// Latency: issue handshake to res_valid is LAT+1 cycles when the result FIFO is empty.
// Backpressure: credit limit of FDEPTH in-flight+buffered results; res_ready never reaches req*_ready combinationally.
module pipe_sched #(
    parameter int N      = 10,
    parameter int LAT    = 3,
    parameter int FDEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [4*N-1:0] req0_ops,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [4*N-1:0] req1_ops,
    output logic           req1_ready,
    output logic [N-1:0]   pipe_a,
    output logic [N-1:0]   pipe_b,
    output logic [N-1:0]   pipe_c,
    output logic [N-1:0]   pipe_d,
    input  logic [N-1:0]   pipe_f,
    output logic           res_valid,
    output logic [N-1:0]   res_data,
    output logic           res_id,
    input  logic           res_ready,
    output logic           busy
);
    localparam int CW = $clog2(FDEPTH + 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4*N-1:0] ops_q, ops_d;
    logic [LAT-1:0] vld_q, vld_d;
    logic [LAT-1:0] id_q, id_d;
    logic           credit_ok;
    logic           issue;
    logic           grant_id;
    logic           pop;

    // Credit check uses only the registered count, keeping res_ready off the ready path.
    assign credit_ok = !rst && (cnt_q < CW'(FDEPTH));
    assign issue     = req0_ready || req1_ready;
    assign grant_id  = req1_ready;
    assign pop       = res_valid && res_ready;
    assign busy      = (cnt_q != '0);

    assign pipe_a = ops_q[4*N-1:3*N];
    assign pipe_b = ops_q[3*N-1:2*N];
    assign pipe_c = ops_q[2*N-1:N];
    assign pipe_d = ops_q[N-1:0];

`ifdef PIPE_SCHED_FIXED_PRIO_EN
    // Strict priority grant: req1 only when req0 is idle.
    always_comb begin
        req0_ready = credit_ok && req0_valid;
        req1_ready = credit_ok && req1_valid && !req0_valid;
    end
`else
    logic last_q, last_d;

    // Round-robin grant: on a tie the requester not granted last wins.
    always_comb begin
        req0_ready = credit_ok && req0_valid && (!req1_valid || last_q);
        req1_ready = credit_ok && req1_valid && (!req0_valid || !last_q);
        last_d     = issue ? grant_id : last_q;
    end

    // Last-granted pointer; reset to 1 so req0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`endif

    // Next-state for operands, in-flight tracker and credits.
    always_comb begin
        ops_d = issue ? (grant_id ? req1_ops : req0_ops) : ops_q;
        vld_d = vld_q;
        id_d  = id_q;
        for (int i = LAT - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
        vld_d[0] = issue;
        id_d[0]  = grant_id;
        cnt_d    = cnt_q;
        if (issue && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!issue && pop) cnt_d = cnt_q - 1'b1;
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q <= '0;
            vld_q <= '0;
            id_q  <= '0;
            cnt_q <= '0;
        end else begin
            ops_q <= ops_d;
            vld_q <= vld_d;
            id_q  <= id_d;
            cnt_q <= cnt_d;
        end
    end

    // Last tracker stage lines up with the pipe result for capture.
    sched_fifo #(.W(N + 1), .DEPTH(FDEPTH)) u_res_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (vld_q[LAT-1]),
        .dat_i  ({id_q[LAT-1], pipe_f}),
        .pop_i  (pop),
        .dat_o  ({res_id, res_data}),
        .vld_o  (res_valid)
    );
endmodule
